// File: rtl/counter_modular.sv
// Modulo-(limit+1) up/down counter with variable step, load and wrap pulse.
// Optional saturating mode enabled by defining COUNTER_MODULAR_SAT_EN.
module counter_modular #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_value,
  input  logic                  dir,
`ifdef COUNTER_MODULAR_SAT_EN
  input  logic                  sat,
`endif
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WORD_WIDTH-1:0] limit,
  output logic [WORD_WIDTH-1:0] count,
  output logic                  tc,
  output logic                  wrap
);

  localparam int W = WORD_WIDTH;

  logic         sat_on;
  logic [W-1:0] stp_w;
  logic [W-1:0] s;
  logic [W:0]   cnt_x;
  logic [W:0]   lim_x;
  logic [W:0]   lim1;
  logic [W:0]   s_x;
  logic [W:0]   sum;
  logic [W-1:0] nxt;
  logic         nwrap;
  logic [W-1:0] ld_val;

`ifdef COUNTER_MODULAR_SAT_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  // All arithmetic in W+1 bits so limit+1 never overflows at all-ones.
  always_comb begin
    stp_w = W'(step);
    s     = (stp_w > limit) ? limit : stp_w;
    cnt_x = {1'b0, count};
    lim_x = {1'b0, limit};
    lim1  = lim_x + (W+1)'(1);
    s_x   = {1'b0, s};
    sum   = cnt_x + s_x;
    nxt   = count;
    nwrap = 1'b0;
    if (count > limit) begin
      nxt   = (dir || sat_on) ? limit : '0;
      nwrap = !sat_on;
    end else if (s != '0) begin
      if (!dir) begin
        if (sum <= lim_x) begin
          nxt = sum[W-1:0];
        end else if (sat_on) begin
          nxt = limit;
        end else begin
          nxt   = W'(sum - lim1);
          nwrap = 1'b1;
        end
      end else begin
        if (s_x <= cnt_x) begin
          nxt = W'(cnt_x - s_x);
        end else if (sat_on) begin
          nxt = '0;
        end else begin
          nxt   = W'(cnt_x + lim1 - s_x);
          nwrap = 1'b1;
        end
      end
    end
  end

  assign ld_val = (load_value > limit) ? limit : load_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= ld_val;
      wrap  <= 1'b0;
    end else if (en) begin
      count <= nxt;
      wrap  <= nwrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

  assign tc = dir ? (count == '0) : (count == limit);

endmodule

// File: tb/tb_counter_modular.sv
// Directed self-checking bench for counter_modular (WORD_WIDTH=8, STEP_WIDTH=4).
// Saturation scenario compiles in when COUNTER_MODULAR_SAT_EN is defined.
module tb_counter_modular;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] load_value;
  logic       dir;
  logic       sat;
  logic [3:0] step;
  logic [7:0] limit;
  logic [7:0] count;
  logic       tc;
  logic       wrap;

  int total = 0;
  int bad = 0;

  counter_modular #(
    .WORD_WIDTH(8),
    .STEP_WIDTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_value(load_value),
    .dir       (dir),
`ifdef COUNTER_MODULAR_SAT_EN
    .sat       (sat),
`endif
    .step      (step),
    .limit     (limit),
    .count     (count),
    .tc        (tc),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b1;
    load = 1'b0;
    load_value = 8'd77;
    dir = 1'b0;
    sat = 1'b0;
    step = 4'd3;
    limit = 8'd9;
    tick();
    tick();
    total++;
    if (count !== 8'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", count);
    end
    total++;
    if (wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_wrap got=%0b want=0", wrap);
    end
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_tc_up got=%0b want=0", tc);
    end
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_c [5] = '{8'd3, 8'd6, 8'd9, 8'd2, 8'd5};
    logic       exp_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    limit = 8'd9;
    dir = 1'b0;
    step = 4'd3;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (count !== exp_c[i] || wrap !== exp_w[i]) begin
        bad++;
        $display("FAIL up_wrap[%0d] got=%0d/%0b want=%0d/%0b",
                 i, count, wrap, exp_c[i], exp_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    limit = 8'd9;
    do_load(8'd1);
    dir = 1'b1;
    step = 4'd4;
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd7 || wrap !== 1'b1 || tc !== 1'b0) begin
      bad++;
      $display("FAIL down_wrap1 got=%0d/%0b/%0b want=7/1/0", count, wrap, tc);
    end
    tick();
    total++;
    if (count !== 8'd3 || wrap !== 1'b0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL down_wrap2 got=%0d/%0b/%0b want=3/0/0", count, wrap, tc);
    end
    en = 1'b0;
    do_load(8'd0);
    total++;
    if (tc !== 1'b1) begin
      bad++;
      $display("FAIL tc_down_zero got=%0b want=1", tc);
    end
    dir = 1'b0;
    #1;
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL tc_up_zero got=%0b want=0", tc);
    end
  endtask

  task automatic test_load();
    limit = 8'd50;
    en = 1'b1;
    dir = 1'b0;
    step = 4'd1;
    do_load(8'd200);
    total++;
    if (count !== 8'd50 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL load_clamp got=%0d/%0b want=50/0", count, wrap);
    end
    do_load(8'd20);
    total++;
    if (count !== 8'd20) begin
      bad++;
      $display("FAIL load_over_en got=%0d want=20", count);
    end
    en = 1'b0;
    tick();
    total++;
    if (count !== 8'd20 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL hold got=%0d/%0b want=20/0", count, wrap);
    end
  endtask

  task automatic test_full_range();
    limit = 8'd255;
    do_load(8'd254);
    dir = 1'b0;
    step = 4'd5;
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd3 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL full_wrap got=%0d/%0b want=3/1", count, wrap);
    end
    step = 4'd0;
    tick();
    total++;
    if (count !== 8'd3 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL step_zero got=%0d/%0b want=3/0", count, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_limit_drop();
    limit = 8'd9;
    do_load(8'd8);
    limit = 8'd5;
    dir = 1'b0;
    step = 4'd1;
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd0 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL limit_drop_up got=%0d/%0b want=0/1", count, wrap);
    end
    en = 1'b0;
    limit = 8'd9;
    do_load(8'd8);
    limit = 8'd5;
    dir = 1'b1;
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd5 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL limit_drop_dn got=%0d/%0b want=5/1", count, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_wrap();
    limit = 8'd9;
    do_load(8'd9);
    dir = 1'b0;
    step = 4'd3;
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd2 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got=%0d/%0b want=2/1", count, wrap);
    end
    reset = 1'b1;
    #1;
    total++;
    if (count !== 8'd0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got=%0d/%0b want=0/0", count, wrap);
    end
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    tick();
    total++;
    if (count !== 8'd0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got=%0d/%0b want=0/0", count, wrap);
    end
  endtask

  task automatic test_back_to_back();
    limit = 8'd9;
    do_load(8'd4);
    dir = 1'b0;
    step = 4'd2;
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd6) begin
      bad++;
      $display("FAIL b2b_up got=%0d want=6", count);
    end
    dir = 1'b1;
    step = 4'd5;
    tick();
    total++;
    if (count !== 8'd1 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL b2b_dn got=%0d/%0b want=1/0", count, wrap);
    end
    limit = 8'd3;
    dir = 1'b0;
    step = 4'd15;
    tick();
    total++;
    if (count !== 8'd0 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL step_clamp got=%0d/%0b want=0/1", count, wrap);
    end
    en = 1'b0;
  endtask

`ifdef COUNTER_MODULAR_SAT_EN
  task automatic test_sat();
    limit = 8'd9;
    sat = 1'b1;
    do_load(8'd8);
    dir = 1'b0;
    step = 4'd3;
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd9 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL sat_up got=%0d/%0b want=9/0", count, wrap);
    end
    tick();
    total++;
    if (count !== 8'd9 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL sat_hold got=%0d/%0b want=9/0", count, wrap);
    end
    en = 1'b0;
    sat = 1'b0;
    do_load(8'd8);
    en = 1'b1;
    tick();
    total++;
    if (count !== 8'd1 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL nosat_up got=%0d/%0b want=1/1", count, wrap);
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_full_range();
    test_limit_drop();
    test_reset_mid_wrap();
    test_back_to_back();
`ifdef COUNTER_MODULAR_SAT_EN
    test_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
